// File: rtl/nav_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nav_ctrl_param: heading / forward-move sequencer with speed ramp, Nth-side- |
// | opening stop and abort. Optional heading timeout: NAV_HDNG_TMO_EN.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module nav_ctrl_param #(
  parameter int SPD_W     = 11,
  parameter int MAX_SPD   = 672,
  parameter int MIN_SPD   = 208,
  parameter int INC       = 24,
  parameter int SLW_SHIFT = 1,
  parameter int FST_SHIFT = 3,
  parameter int HDNG_FILT = 3,
  parameter int OPN_W     = 3
`ifdef NAV_HDNG_TMO_EN
  , parameter int TMO_CYC = 1000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_hdng,
  input  logic             strt_mv,
  input  logic             stp_lft,
  input  logic             stp_rght,
  input  logic [OPN_W-1:0] opn_num,
  input  logic             abort,
  input  logic             hdng_rdy,
  input  logic             at_hdng,
  input  logic             lft_opn,
  input  logic             rght_opn,
  input  logic             frwrd_opn,
  output logic             mv_cmplt,
  output logic             moving,
  output logic             en_fusion,
  output logic [SPD_W-1:0] frwrd_spd,
  output logic             hdng_tmo
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDNG    = 3'd1,
    S_MV      = 3'd2,
    S_DEC_SLW = 3'd3,
    S_DEC_FST = 3'd4
  } state_t;

  localparam int FILT_W = $clog2(HDNG_FILT + 1);

  localparam logic [SPD_W:0]     c_inc     = (SPD_W+1)'(INC);
  localparam logic [SPD_W:0]     c_max     = (SPD_W+1)'(MAX_SPD);
  localparam logic [SPD_W:0]     c_slw     = (SPD_W+1)'(INC << SLW_SHIFT);
  localparam logic [SPD_W:0]     c_fst     = (SPD_W+1)'(INC << FST_SHIFT);
  localparam logic [SPD_W-1:0]   c_min     = SPD_W'(MIN_SPD);
  localparam logic [SPD_W-1:0]   c_half    = SPD_W'(MAX_SPD / 2);
  localparam logic [FILT_W-1:0]  c_filt    = FILT_W'(HDNG_FILT);
  localparam logic [OPN_W-1:0]   c_opn_max = {OPN_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [SPD_W-1:0]   r_spd, w_spd_nxt;
  logic [FILT_W-1:0]  r_filt, w_filt_nxt;
  logic [OPN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [OPN_W-1:0]   r_tgt, w_tgt_nxt;
  logic               r_lft_s1, r_lft_s2, r_rght_s1, r_rght_s2;

  logic [SPD_W:0]     w_up_sum;
  logic [SPD_W-1:0]   w_ramp_up, w_dec_slw, w_dec_fst;
  logic [FILT_W-1:0]  w_filt_upd;
  logic               w_filt_done, w_qual, w_tgt_hit, w_tmo_hit;

  // Ramp arithmetic carries one guard bit so the clamp sees the true sum.
  assign w_up_sum  = {1'b0, r_spd} + c_inc;
  assign w_ramp_up = (w_up_sum > c_max) ? c_max[SPD_W-1:0] : w_up_sum[SPD_W-1:0];
  assign w_dec_slw = ({1'b0, r_spd} <= c_slw) ? '0 : r_spd - c_slw[SPD_W-1:0];
  assign w_dec_fst = ({1'b0, r_spd} <= c_fst) ? '0 : r_spd - c_fst[SPD_W-1:0];

  assign w_filt_upd  = at_hdng ? ((r_filt == c_filt) ? r_filt : r_filt + 1'b1) : '0;
  assign w_filt_done = (w_filt_upd == c_filt);

  assign w_qual    = (r_lft_s1 & ~r_lft_s2 & stp_lft) | (r_rght_s1 & ~r_rght_s2 & stp_rght);
  assign w_tgt_hit = (({1'b0, r_cnt} + 1'b1) == {1'b0, r_tgt});

  assign frwrd_spd = r_spd;
  assign en_fusion = (r_spd > c_half);

`ifdef NAV_HDNG_TMO_EN
  localparam int TCNT_W = $clog2(TMO_CYC + 1);
  localparam logic [TCNT_W-1:0] c_tmo_last = TCNT_W'(TMO_CYC - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_tmo;

  assign w_tmo_hit = (r_state == S_HDNG) && (r_tcnt == c_tmo_last);
  assign hdng_tmo  = r_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (r_state == S_HDNG) r_tcnt <= r_tcnt + 1'b1;
      else                   r_tcnt <= '0;
      if (r_state == S_IDLE && (strt_hdng || strt_mv)) r_tmo <= 1'b0;
      else if (w_tmo_hit)                              r_tmo <= 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign hdng_tmo  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_spd     <= '0;
      r_filt    <= '0;
      r_cnt     <= '0;
      r_tgt     <= '0;
      r_lft_s1  <= 1'b0;
      r_lft_s2  <= 1'b0;
      r_rght_s1 <= 1'b0;
      r_rght_s2 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_spd     <= w_spd_nxt;
      r_filt    <= w_filt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tgt     <= w_tgt_nxt;
      r_lft_s1  <= lft_opn;
      r_lft_s2  <= r_lft_s1;
      r_rght_s1 <= rght_opn;
      r_rght_s2 <= r_rght_s1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_spd_nxt   = r_spd;
    w_filt_nxt  = r_filt;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    mv_cmplt    = 1'b0;
    moving      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_filt_nxt = '0;
        if (strt_hdng) begin
          w_state_nxt = S_HDNG;
          moving      = 1'b1;
        end else if (strt_mv) begin
          w_state_nxt = S_MV;
          w_spd_nxt   = c_min;
          w_tgt_nxt   = (opn_num == '0) ? OPN_W'(1) : opn_num;
          w_cnt_nxt   = '0;
          moving      = 1'b1;
        end
      end
      S_HDNG: begin
        w_filt_nxt = w_filt_upd;
        if (abort || w_filt_done || w_tmo_hit) begin
          mv_cmplt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          moving = 1'b1;
        end
      end
      S_MV: begin
        moving = 1'b1;
        if (hdng_rdy) w_spd_nxt = w_ramp_up;
        if (abort || !frwrd_opn) begin
          w_state_nxt = S_DEC_FST;
        end else if (w_qual) begin
          if (w_tgt_hit)             w_state_nxt = S_DEC_SLW;
          else if (r_cnt != c_opn_max) w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DEC_SLW: begin
        if (r_spd == '0) begin
          mv_cmplt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          moving = 1'b1;
          if (hdng_rdy) w_spd_nxt = w_dec_slw;
          if (abort || !frwrd_opn) w_state_nxt = S_DEC_FST;
        end
      end
      S_DEC_FST: begin
        if (r_spd == '0) begin
          mv_cmplt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          moving = 1'b1;
          if (hdng_rdy) w_spd_nxt = w_dec_fst;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nav_ctrl_param.sv
`default_nettype none
// Directed bench for nav_ctrl_param: expectations queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_nav_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n, strt_hdng, strt_mv, stp_lft, stp_rght, abort;
  logic        hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn;
  logic [2:0]  opn_num;
  logic        mv_cmplt, moving, en_fusion, hdng_tmo;
  logic [10:0] frwrd_spd;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  nav_ctrl_param #(
    .SPD_W(11), .MAX_SPD(672), .MIN_SPD(208), .INC(24),
    .SLW_SHIFT(1), .FST_SHIFT(3), .HDNG_FILT(3), .OPN_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .opn_num(opn_num), .abort(abort),
    .hdng_rdy(hdng_rdy), .at_hdng(at_hdng), .lft_opn(lft_opn),
    .rght_opn(rght_opn), .frwrd_opn(frwrd_opn), .mv_cmplt(mv_cmplt),
    .moving(moving), .en_fusion(en_fusion), .frwrd_spd(frwrd_spd),
    .hdng_tmo(hdng_tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %0d, expected a queued value", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic pulse_rdy();
    hdng_rdy = 1'b1;
    tick();
    hdng_rdy = 1'b0;
  endtask

  initial begin
    int exp_spd;
    int run;
    int dec_vals[4] = '{480, 288, 96, 0};
    int pat[6]      = '{1, 1, 0, 1, 1, 1};

    rst_n = 1'b0; strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0;
    stp_rght = 1'b0; abort = 1'b0; hdng_rdy = 1'b0; at_hdng = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0; opn_num = 3'd0;
    tick(); tick();

    // Reset state
    push("rst_spd", 0);      chk(32'(frwrd_spd));
    push("rst_moving", 0);   chk(32'(moving));
    push("rst_cmplt", 0);    chk(32'(mv_cmplt));
    push("rst_fusion", 0);   chk(32'(en_fusion));
    push("rst_tmo", 0);      chk(32'(hdng_tmo));
    rst_n = 1'b1;
    tick();

    // Ramp and clamp
    frwrd_opn = 1'b1;
    strt_mv = 1'b1;
    #1;
    push("accept_moving", 1); chk(32'(moving));
    tick();
    strt_mv = 1'b0;
    push("mv_start_spd", 208); chk(32'(frwrd_spd));
    exp_spd = 208;
    for (int k = 0; k < 20; k++) begin
      exp_spd = (exp_spd + 24 > 672) ? 672 : exp_spd + 24;
      push("ramp_spd", 32'(exp_spd));
      push("ramp_fusion", (exp_spd > 336) ? 1 : 0);
      pulse_rdy();
      chk(32'(frwrd_spd));
      chk(32'(en_fusion));
    end

    // Fast decel on loss of forward opening
    frwrd_opn = 1'b0;
    push("fst_hold_spd", 672);
    tick();
    chk(32'(frwrd_spd));
    for (int k = 0; k < 4; k++) begin
      push("fst_spd", 32'(dec_vals[k]));
      push("fst_moving", (dec_vals[k] != 0) ? 1 : 0);
      pulse_rdy();
      chk(32'(frwrd_spd));
      if (dec_vals[k] != 0) chk(32'(moving));
      else void'(sb_q.pop_back());
    end
    push("fst_cmplt", 1);        chk(32'(mv_cmplt));
    push("fst_cmplt_moving", 0); chk(32'(moving));
    tick();
    push("fst_cmplt_once", 0);   chk(32'(mv_cmplt));
    push("idle_moving", 0);      chk(32'(moving));

    // Nth opening: stop at 2nd left rise; right rises ignored
    frwrd_opn = 1'b1; stp_lft = 1'b1; opn_num = 3'd2;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    pulse_rdy(); pulse_rdy();
    push("nth_pre_spd", 256); chk(32'(frwrd_spd));
    rght_opn = 1'b1; tick(); rght_opn = 1'b0; tick(); tick();
    lft_opn = 1'b1; tick(); lft_opn = 1'b0; tick(); tick(); tick();
    push("nth_first_ignored", 280);
    pulse_rdy();
    chk(32'(frwrd_spd));
    lft_opn = 1'b1;
    tick();
    lft_opn = 1'b0;
    push("nth_edge_timing", 304);
    pulse_rdy();
    chk(32'(frwrd_spd));
    push("slw_step", 256);
    pulse_rdy();
    chk(32'(frwrd_spd));
    lft_opn = 1'b1; tick(); lft_opn = 1'b0; tick(); tick();
    exp_spd = 256;
    for (int k = 0; k < 6; k++) begin
      exp_spd = (exp_spd <= 48) ? 0 : exp_spd - 48;
      push("slw_spd", 32'(exp_spd));
      pulse_rdy();
      chk(32'(frwrd_spd));
    end
    push("slw_cmplt", 1); chk(32'(mv_cmplt));
    tick();
    stp_lft = 1'b0;

    // Heading filter
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    run = 0;
    for (int i = 0; i < 6; i++) begin
      at_hdng = pat[i][0];
      run = (pat[i] != 0) ? run + 1 : 0;
      push("hdng_cmplt", (run >= 3) ? 1 : 0);
      push("hdng_moving", (run < 3) ? 1 : 0);
      #1;
      chk(32'(mv_cmplt));
      chk(32'(moving));
      tick();
    end
    at_hdng = 1'b0;
    push("hdng_idle_moving", 0); chk(32'(moving));

    // Simultaneous starts: heading wins
    strt_hdng = 1'b1; strt_mv = 1'b1;
    tick();
    strt_hdng = 1'b0; strt_mv = 1'b0;
    push("both_spd", 0);    chk(32'(frwrd_spd));
    push("both_moving", 1); chk(32'(moving));
    abort = 1'b1;
    #1;
    push("hdng_abort_cmplt", 1); chk(32'(mv_cmplt));
    tick();
    abort = 1'b0;
    push("hdng_abort_idle", 0); chk(32'(moving));

    // Abort in MV at 400
    opn_num = 3'd0;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    for (int k = 0; k < 8; k++) pulse_rdy();
    push("abort_pre_spd", 400); chk(32'(frwrd_spd));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    push("abort_spd0", 208); pulse_rdy(); chk(32'(frwrd_spd));
    push("abort_spd1", 16);  pulse_rdy(); chk(32'(frwrd_spd));
    push("abort_spd2", 0);   pulse_rdy(); chk(32'(frwrd_spd));
    push("abort_cmplt", 1);  chk(32'(mv_cmplt));
    tick();

    // Reset mid DEC_SLW
    opn_num = 3'd1; stp_lft = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    pulse_rdy(); pulse_rdy();
    lft_opn = 1'b1; tick(); lft_opn = 1'b0; tick();
    push("rst_mid_pre", 208);
    pulse_rdy();
    chk(32'(frwrd_spd));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push("rst_mid_spd", 0);    chk(32'(frwrd_spd));
    push("rst_mid_cmplt", 0);  chk(32'(mv_cmplt));
    push("rst_mid_moving", 0); chk(32'(moving));
    tick();
    push("rst_mid_no_cmplt", 0); chk(32'(mv_cmplt));
    stp_lft = 1'b0;

    // Heading without timeout feature waits indefinitely
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    push("hdng_wait_moving", 1);
    push("hdng_wait_tmo", 0);
    push("hdng_wait_cmplt", 0);
    for (int k = 0; k < 1000; k++) tick();
    chk(32'(moving));
    chk(32'(hdng_tmo));
    chk(32'(mv_cmplt));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nav_ctrl_param.md
Name: nav_ctrl_param

Overview:
Parametrised next-generation heading/forward-move sequencer for the maze robot. It accepts heading and move commands from the command layer and drives the forward-speed ramp into the PID, with IR-opening-based stopping. New over the previous generation:
- configurable widths and ramp rates
- saturating ramp clamp
- stop at the Nth qualifying side opening
- abort input
- compile-time heading timeout

Parameters:
SPD_W, 11, width of frwrd_spd
MAX_SPD, 672, forward speed ceiling (unsigned, < 2^SPD_W)
MIN_SPD, 208, speed loaded on move start
INC, 24, acceleration step per hdng_rdy
SLW_SHIFT, 1, slow-decel step = INC << SLW_SHIFT
FST_SHIFT, 3, fast-decel step = INC << FST_SHIFT
HDNG_FILT, 3, consecutive at_hdng cycles required to finish heading (>=1)
OPN_W, 3, width of opn_num
TMO_CYC, 1000000, heading timeout in clk cycles (only with NAV_HDNG_TMO_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
strt_hdng  in  1  start heading command (pulse)
strt_mv  in  1  start forward move command (pulse)
stp_lft  in  1  stop on left openings
stp_rght  in  1  stop on right openings
opn_num  in  OPN_W  stop at this qualifying opening count; 0 treated as 1; sampled at strt_mv
abort  in  1  stop current operation
hdng_rdy  in  1  ramp pacing strobe
at_hdng  in  1  PID heading-reached flag
lft_opn, rght_opn, frwrd_opn  in  1 each  IR opening flags
mv_cmplt  out  1  one-cycle completion pulse
moving  out  1  integrator enable
en_fusion  out  1  frwrd_spd > MAX_SPD/2 (integer divide)
frwrd_spd  out  SPD_W  unsigned forward speed
hdng_tmo  out  1  heading timed out (sticky until next strt_hdng/strt_mv)

Behaviour:
- Reset (rst_n low at clk edge) clears:
  - state → IDLE
  - frwrd_spd → 0; hdng_tmo → 0
  - filter counter, opening counter, edge-detect flops → 0
  - resulting outputs: mv_cmplt=0, moving=0, en_fusion=0
- Reset mid-operation aborts immediately; no decel ramp.
- States: IDLE, HDNG, MV, DEC_SLW, DEC_FST. mv_cmplt and moving are combinational from state and registers; all other state is registered.
- IDLE:
  - strt_hdng → HDNG.
  - else strt_mv → MV, frwrd_spd ← MIN_SPD, latch target = (opn_num==0 ? 1 : opn_num), opening count ← 0.
  - If both arrive the same cycle, heading wins.
  - moving=1 in the accepting cycle.
- strt_hdng and strt_mv outside IDLE are ignored.
- HDNG:
  - Filter counter increments while at_hdng=1 (saturates at HDNG_FILT) and clears when at_hdng=0.
  - When the counter reaches HDNG_FILT: mv_cmplt=1, → IDLE.
  - Otherwise moving=1.
  - abort → IDLE with mv_cmplt=1 the same cycle.
- MV:
  - moving=1.
  - On hdng_rdy: frwrd_spd ← min(frwrd_spd+INC, MAX_SPD). Compute with one guard bit; never wraps.
  - Exit priority: abort or !frwrd_opn → DEC_FST; then reaching the opening target → DEC_SLW.
- Openings:
  - lft_opn and rght_opn are each double-flopped; rise = cur & ~prev.
  - A qualifying event is (lft rise & stp_lft) | (rght rise & stp_rght). Simultaneous left and right rises count once.
  - When count+1 == target on a qualifying event, → DEC_SLW; otherwise count increments (saturating at 2^OPN_W−1).
- DEC_SLW / DEC_FST:
  - On hdng_rdy, subtract the step (INC<<SLW_SHIFT or INC<<FST_SHIFT); if frwrd_spd ≤ step, load 0.
  - While frwrd_spd != 0: moving=1.
  - When frwrd_spd==0: mv_cmplt=1, moving=0, → IDLE.
  - abort in DEC_SLW → DEC_FST. !frwrd_opn in DEC_SLW → DEC_FST.
- en_fusion is purely combinational from frwrd_spd.

Optional Feature:
NAV_HDNG_TMO_EN:
- Defined: a cycle counter clears on HDNG entry and increments in HDNG. On reaching TMO_CYC: hdng_tmo ← 1, mv_cmplt=1, → IDLE. hdng_tmo clears on the next accepted command.
- Undefined: no counter; hdng_tmo tied 0; HDNG waits indefinitely.

Test Plan:
- Ramp and clamp: strt_mv, frwrd_opn=1, 20 hdng_rdy pulses → frwrd_spd 208, 232, … 664, then 672 (clamped, not 688); en_fusion rises when frwrd_spd first exceeds 336 (at 352).
- Fast decel: at 672 drop frwrd_opn → 480, 288, 96, 0 on successive hdng_rdy; mv_cmplt high exactly 1 cycle; then IDLE and moving=0.
- Nth opening: opn_num=2, stp_lft=1, three lft_opn pulses → first ignored, DEC_SLW entered on second rise (2 cycles after the input edge), ramp steps of 48, third pulse ignored.
- Heading filter: strt_hdng, at_hdng pattern 1,1,0,1,1,1 → mv_cmplt on the 3rd consecutive high only; strt_hdng + strt_mv together → HDNG.
- Abort/reset: abort in MV at 400 → DEC_FST (208, 16, 0); rst_n low mid-DEC_SLW → next cycle frwrd_spd=0, IDLE, no mv_cmplt.
- Timeout (NAV_HDNG_TMO_EN, TMO_CYC=50): at_hdng held 0 → hdng_tmo=1 and mv_cmplt pulse at cycle 50; without the macro, no exit after 1000 cycles.
